// File: rtl/pcs_tx_symb_fifo.sv
// pcs_tx_symb_fifo
// Transmit symbol-vector elastic buffer between the PCS TX encoder and the
// PMA. It accepts vectors over valid/ready and releases one vector per PMA
// symbol-timer strobe once a prefill level has been reached. If the buffer
// is empty when a strobe arrives in RUN, an all-zero vector is sent and the
// underrun is flagged.
// Optional feature: define PCS_TX_SYMB_FIFO_STATS_EN to add the underrun
// counter and high-water-mark outputs. Only reset clears them.
module pcs_tx_symb_fifo #(
  parameter int NUM_LANES   = 4,
  parameter int SYM_W       = 3,
  parameter int DEPTH       = 8,
  parameter int START_LEVEL = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             io_flush,
  input  logic                             io_in_valid,
  output logic                             io_in_ready,
  input  logic [NUM_LANES*SYM_W-1:0]       io_in_bits,
  input  logic                             io_symb_timer_done,
  output logic                             io_out_valid,
  output logic [NUM_LANES*SYM_W-1:0]       io_out_bits,
  output logic                             io_out_underrun,
  output logic [$clog2(DEPTH+1)-1:0]       io_count
`ifdef PCS_TX_SYMB_FIFO_STATS_EN
  ,
  output logic [15:0]                      io_underrun_cnt,
  output logic [$clog2(DEPTH+1)-1:0]       io_max_level
`endif
);

  localparam int VEC_W = NUM_LANES * SYM_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [VEC_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [VEC_W-1:0] out_bits_q, out_bits_d;
  logic             out_valid_q, out_valid_d;
  logic             out_underrun_q, out_underrun_d;

  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             underrun_s;

  // Ready comes only from registered occupancy. A same-cycle pop does not free a slot.
  assign in_ready_s  = !reset && (count_q < CNT_W'(DEPTH));
  assign io_in_ready = in_ready_s;

  // Next-state logic for pointers, occupancy, FILL/RUN state and the output register
  always_comb begin
    push_s         = 1'b0;
    pop_s          = 1'b0;
    underrun_s     = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    out_bits_d     = out_bits_q;
    out_valid_d    = 1'b0;
    out_underrun_d = 1'b0;

    if (io_flush) begin
      // On flush, drop any same-cycle push, ignore the strobe and return to FILL.
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      state_d    = ST_FILL;
      out_bits_d = {VEC_W{1'b0}};
    end else begin
      push_s = io_in_valid && in_ready_s;

      case (state_q)
        ST_RUN: begin
          if (io_symb_timer_done) begin
            out_valid_d = 1'b1;
            if (count_q != {CNT_W{1'b0}}) begin
              // Occupancy is registered, so a push in this cycle is never bypassed to the output.
              pop_s      = 1'b1;
              out_bits_d = mem_q[rd_ptr_q];
            end else begin
              underrun_s     = 1'b1;
              out_underrun_d = 1'b1;
              out_bits_d     = {VEC_W{1'b0}};
              state_d        = ST_FILL;
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
        default: begin
          // FILL: send zero vectors until the prefill level is reached.
          if (io_symb_timer_done) begin
            out_valid_d = 1'b1;
            out_bits_d  = {VEC_W{1'b0}};
          end else begin
            out_valid_d = 1'b0;
          end
        end
      endcase

      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if ((state_q == ST_FILL) && (count_d >= CNT_W'(START_LEVEL))) begin
        state_d = ST_RUN;
      end else begin
        state_d = state_d;
      end
    end
  end

  // Control and output registers, with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      state_q        <= ST_FILL;
      out_bits_q     <= {VEC_W{1'b0}};
      out_valid_q    <= 1'b0;
      out_underrun_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      out_bits_q     <= out_bits_d;
      out_valid_q    <= out_valid_d;
      out_underrun_q <= out_underrun_d;
    end
  end

  // Vector storage. It is data only and needs no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= io_in_bits;
    end
  end

  assign io_out_bits     = out_bits_q;
  assign io_out_valid    = out_valid_q;
  assign io_out_underrun = out_underrun_q;
  assign io_count        = count_q;

`ifdef PCS_TX_SYMB_FIFO_STATS_EN
  logic [15:0]      underrun_cnt_q, underrun_cnt_d;
  logic [CNT_W-1:0] max_level_q, max_level_d;

  // Next-state logic for the saturating underrun counter and the occupancy high-water mark
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    max_level_d    = max_level_q;
    if (underrun_s && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end else begin
      underrun_cnt_d = underrun_cnt_q;
    end
    if (count_d > max_level_q) begin
      max_level_d = count_d;
    end else begin
      max_level_d = max_level_q;
    end
  end

  // Statistics registers. Reset clears them and flush does not.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun_cnt_q <= 16'd0;
      max_level_q    <= {CNT_W{1'b0}};
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      max_level_q    <= max_level_d;
    end
  end

  assign io_underrun_cnt = underrun_cnt_q;
  assign io_max_level    = max_level_q;
`endif

endmodule

// File: tb/tb_pcs_tx_symb_fifo.sv
// Self-checking bench for pcs_tx_symb_fifo (default parameters).
// A queue scoreboard receives each vector the bench expects the FIFO to
// accept. The entry is popped when a strobe in RUN should release it.
module tb_pcs_tx_symb_fifo;

  logic        clock;
  logic        reset;
  logic        io_flush;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [11:0] io_in_bits;
  logic        io_symb_timer_done;
  logic        io_out_valid;
  logic [11:0] io_out_bits;
  logic        io_out_underrun;
  logic [3:0]  io_count;
`ifdef PCS_TX_SYMB_FIFO_STATS_EN
  logic [15:0] io_underrun_cnt;
  logic [3:0]  io_max_level;
`endif

  pcs_tx_symb_fifo dut (
    .clock              (clock),
    .reset              (reset),
    .io_flush           (io_flush),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits         (io_in_bits),
    .io_symb_timer_done (io_symb_timer_done),
    .io_out_valid       (io_out_valid),
    .io_out_bits        (io_out_bits),
    .io_out_underrun    (io_out_underrun),
    .io_count           (io_count)
`ifdef PCS_TX_SYMB_FIFO_STATS_EN
    ,
    .io_underrun_cnt    (io_underrun_cnt),
    .io_max_level       (io_max_level)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Scoreboard and reference model state
  logic [11:0] sb_q [$];
  bit          m_run;
  logic [11:0] m_bits;
  bit          m_v;
  bit          m_u;
  int          m_unr;
  int          m_max;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    logic [2:0] la, lb, lc, ld;
    la = 3'(a); lb = 3'(b); lc = 3'(c); ld = 3'(d);
    return {ld, lc, lb, la};
  endfunction

  // Drive one clock cycle, advance the model, then check all outputs.
  task automatic cyc(input bit v, input logic [11:0] b, input bit s, input bit f);
    bit acc;
    bit prev_run;
    acc = v && (sb_q.size() < 8) && !f;
    check_eq("in_ready_pre", 32'(io_in_ready), 32'(sb_q.size() < 8));
    io_in_valid = v; io_in_bits = b; io_symb_timer_done = s; io_flush = f;
    @(posedge clock); #1;
    io_in_valid = 1'b0; io_symb_timer_done = 1'b0; io_flush = 1'b0;
    if (f) begin
      sb_q.delete(); m_run = 1'b0; m_bits = 12'd0; m_v = 1'b0; m_u = 1'b0;
    end else begin
      prev_run = m_run; m_v = 1'b0; m_u = 1'b0;
      if (s) begin
        m_v = 1'b1;
        if (m_run && sb_q.size() > 0) begin
          m_bits = sb_q.pop_front();
        end else if (m_run) begin
          m_bits = 12'd0; m_u = 1'b1; m_run = 1'b0;
          if (m_unr < 65535) m_unr++;
        end else begin
          m_bits = 12'd0;
        end
      end
      if (acc) sb_q.push_back(b);
      if (!prev_run && sb_q.size() >= 4) m_run = 1'b1;
    end
    if (sb_q.size() > m_max) m_max = sb_q.size();
    check_eq("out_valid", 32'(io_out_valid), 32'(m_v));
    check_eq("out_underrun", 32'(io_out_underrun), 32'(m_u));
    check_eq("out_bits", 32'(io_out_bits), 32'(m_bits));
    check_eq("count", 32'(io_count), 32'(sb_q.size()));
  endtask

  initial begin
    reset = 1'b1; io_flush = 1'b0; io_in_valid = 1'b1; io_in_bits = 12'hABC;
    io_symb_timer_done = 1'b0;
    m_run = 1'b0; m_bits = 12'd0; m_v = 1'b0; m_u = 1'b0; m_unr = 0; m_max = 0;

    // Reset held for two cycles with valid asserted
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check_eq("rst_ready", 32'(io_in_ready), 32'd0);
      check_eq("rst_count", 32'(io_count), 32'd0);
      check_eq("rst_bits", 32'(io_out_bits), 32'd0);
      check_eq("rst_valid", 32'(io_out_valid), 32'd0);
    end
    reset = 1'b0; io_in_valid = 1'b0;
    @(posedge clock); #1;
    check_eq("post_rst_ready", 32'(io_in_ready), 32'd1);
    check_eq("post_rst_count", 32'(io_count), 32'd0);
    check_eq("post_rst_valid", 32'(io_out_valid), 32'd0);
    check_eq("post_rst_under", 32'(io_out_underrun), 32'd0);

    // Prefill
    cyc(1'b1, pk(1, -1, 2, -2), 1'b0, 1'b0);
    cyc(1'b1, pk(0, 0, 0, 1), 1'b0, 1'b0);
    cyc(1'b1, pk(2, 2, -2, -2), 1'b0, 1'b0);
    cyc(1'b0, 12'd0, 1'b1, 1'b0);
    check_eq("prefill_zero_out", 32'(io_out_bits), 32'd0);
    check_eq("prefill_count", 32'(io_count), 32'd3);
    cyc(1'b1, pk(-1, 3, -4, 0), 1'b0, 1'b0);
    cyc(1'b0, 12'd0, 1'b1, 1'b0);
    check_eq("first_vec", 32'(io_out_bits), 32'(12'b110_010_111_001));
    check_eq("first_vec_count", 32'(io_count), 32'd3);

    // Backpressure
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'(12'h100 + i), 1'b0, 1'b0);
    cyc(1'b1, 12'h5A5, 1'b0, 1'b0);
    check_eq("full_count", 32'(io_count), 32'd8);
    check_eq("full_ready", 32'(io_in_ready), 32'd0);
    cyc(1'b1, 12'h5A5, 1'b1, 1'b0);
    check_eq("after_pop_ready", 32'(io_in_ready), 32'd1);
    cyc(1'b1, 12'h5A5, 1'b0, 1'b0);
    check_eq("ninth_accepted", 32'(io_count), 32'd8);

    // Underrun after back-to-back strobes drain the FIFO
    for (int i = 0; i < 8; i++) cyc(1'b0, 12'd0, 1'b1, 1'b0);
    cyc(1'b0, 12'd0, 1'b1, 1'b0);
    check_eq("underrun_pulse", 32'(io_out_underrun), 32'd1);
    cyc(1'b0, 12'd0, 1'b0, 1'b0);
`ifdef PCS_TX_SYMB_FIFO_STATS_EN
    check_eq("underrun_cnt", 32'(io_underrun_cnt), 32'd1);
`endif
    cyc(1'b1, 12'h321, 1'b1, 1'b0);

    // Flush mid-stream at count 5
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'(12'h200 + i), 1'b0, 1'b0);
    check_eq("pre_flush_count", 32'(io_count), 32'd5);
    cyc(1'b1, 12'h777, 1'b1, 1'b1);
    check_eq("flush_count", 32'(io_count), 32'd0);
    check_eq("flush_valid", 32'(io_out_valid), 32'd0);
    check_eq("flush_bits", 32'(io_out_bits), 32'd0);
    cyc(1'b0, 12'd0, 1'b1, 1'b0);
    check_eq("post_flush_under", 32'(io_out_underrun), 32'd0);

    // Simultaneous push and pop with pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'(12'h300 + i), 1'b0, 1'b0);
    cyc(1'b0, 12'd0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 12'($urandom), 1'b1, 1'b0);
    check_eq("simul_count", 32'(io_count), 32'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 12'd0, 1'b1, 1'b0);
    cyc(1'b0, 12'd0, 1'b0, 1'b0);
`ifdef PCS_TX_SYMB_FIFO_STATS_EN
    check_eq("underrun_cnt_end", 32'(io_underrun_cnt), 32'(m_unr));
    check_eq("max_level", 32'(io_max_level), 32'(m_max));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcs_tx_symb_fifo.md
# pcs_tx_symb_fifo

Parametrised transmit symbol-vector elastic buffer sitting between the PCS transmit encoder / TX state machine and the PMA transmit interface. Accepts NUM_LANES-wide vectors of signed PAM symbols over a valid/ready handshake at encoder rate, stores up to DEPTH vectors, and releases exactly one vector per PMA symbol-timer strobe. A prefill threshold absorbs encoder jitter. Underruns are filled with zero symbols and flagged, so the PMA always sees a defined vector on every symbol period.

## Interface
- NUM_LANES, 4, number of symbol lanes per vector; lane 0 = A, 1 = B, 2 = C, 3 = D.
- SYM_W, 3, bits per signed two's-complement symbol.
- DEPTH, 8, FIFO depth in vectors; power of two, ≥ 2.
- START_LEVEL, 4, occupancy required before draining starts; 1..DEPTH.

- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- io_flush  in  1  synchronous flush, the PCS-reset equivalent.
- io_in_valid  in  1  encoder vector valid.
- io_in_ready  out  1  FIFO can accept a vector.
- io_in_bits  in  NUM_LANES*SYM_W  input vector; lane i at [i*SYM_W +: SYM_W].
- io_symb_timer_done  in  1  PMA symbol-period strobe; one-cycle pulse.
- io_out_valid  out  1  one-cycle pulse marking a new output vector.
- io_out_bits  out  NUM_LANES*SYM_W  output vector; same packing as the input.
- io_out_underrun  out  1  one-cycle pulse, aligned with io_out_valid, when an underrun occurs.
- io_count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Storage:** circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in a separate count register from 0 to DEPTH. Symbols pass through unmodified, with no sign handling.
- **Push:** occurs when io_in_valid && io_in_ready.
- **io_in_ready:** equals !reset && (count < DEPTH). It is combinational from registered state and is not relieved by a same-cycle pop.
- **State machine:**
  - FILL (reset state):
    - On each strobe, the output register loads all-zero and io_out_valid pulses. Nothing is popped and io_out_underrun stays 0.
    - FILL → RUN at the clock edge where the next-state count ≥ START_LEVEL.
  - RUN, on each strobe:
    - If count > 0 at the strobe cycle: pop the head into the output register and pulse io_out_valid.
    - If count == 0: load all-zero, pulse io_out_valid and io_out_underrun, and go RUN → FILL.
- **Simultaneous push and pop:** count is unchanged and FIFO order is preserved. A push into an empty FIFO is never bypassed to a same-cycle pop; that case is an underrun.
- **io_flush:**
  - Clears pointers and count, forces FILL, zeroes io_out_bits, and suppresses io_out_valid and io_out_underrun.
  - A push presented in the same cycle is dropped.
  - A strobe in the flush cycle is ignored.
  - Statistics are not cleared.
- **reset:** performs everything io_flush does, and also clears statistics.
- **Output values while reset is asserted and on the following cycle:** io_out_valid=0, io_out_underrun=0, io_out_bits=0, io_count=0. io_in_ready becomes 1 on the first cycle after reset deasserts.

## Timing
- The strobe is sampled at edge k. io_out_bits updates at edge k, and io_out_valid / io_out_underrun are high for the cycle following edge k.
- io_out_bits holds its value until the next strobe.
- Fill-to-output latency: a vector pushed at edge k into an empty FIFO in RUN is not output by a strobe at edge k. It is eligible from the strobe at edge k+1 onward.
- io_count reflects the push/pop of the previous edge. No combinational path runs from io_symb_timer_done to any output.
- Back-to-back strobes on consecutive cycles are legal and each one pops.

## Configuration
- Macro: PCS_TX_SYMB_FIFO_STATS_EN.
- **Defined:** adds two output ports.
  - io_underrun_cnt, out, 16 bits: increments on every io_out_underrun pulse and saturates at 0xFFFF.
  - io_max_level, out, $clog2(DEPTH+1) bits: high-water mark of count.
  - Both are cleared only by reset; io_flush does not clear them.
- **Undefined:** both ports and their logic are absent. All other behaviour is identical.

## Test plan
1. **Reset:** hold reset 2 cycles with io_in_valid=1 → io_in_ready=0, io_count=0, io_out_bits=0, io_out_valid=0 throughout; io_in_ready=1 the cycle after release.
2. **Prefill:**
   - Push 3 vectors {A=1,B=-1,C=2,D=-2}, {0,0,0,1}, {2,2,-2,-2}, then strobe → io_out_bits=0, io_out_valid=1, io_out_underrun=0, io_count=3.
   - Push a 4th vector, then strobe → first vector {1,-1,2,-2} is output and io_count=3.
3. **Backpressure (DEPTH=8):** push 8 vectors with no strobe → io_count=8, io_in_ready=0, and a 9th valid vector is held. A strobe pops once; io_in_ready=1 the next cycle and the 9th vector is accepted.
4. **Underrun:**
   - In RUN, drain to io_count=0, then strobe → io_out_bits=0, io_out_valid=1, io_out_underrun=1 for one cycle, and the state returns to FILL.
   - With the STATS macro defined, io_underrun_cnt=1.
5. **Flush mid-stream:** at io_count=5 in RUN, assert io_flush together with a strobe → next cycle io_count=0, io_out_valid=0, io_out_bits=0. A later strobe outputs zeros with io_out_underrun=0.
6. **Simultaneous push/pop:** at io_count=3 in RUN, push and strobe in the same cycle → io_count stays 3, and the output sequence matches push order exactly across 300 vectors including pointer wrap-around.
